// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not borrow.
module div_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_trial;
  logic           w_unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit is never shifted in.
  assign w_unused_rem_msb = rem_in[WIDTH];

  // Shift and trial subtract; MSB of the trial is the borrow.
  always_comb begin
    w_sh    = {rem_in[WIDTH-1:0], quo_msb};
    w_trial = w_sh - {1'b0, divisor};
    q_bit   = ~w_trial[WIDTH];
    rem_out = q_bit ? w_trial : w_sh;
  end

endmodule : div_step

// File: rtl/div_4bit_seq.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Divide-by-zero completes immediately with quotient all ones, remainder = dividend.
module div_4bit_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;

  logic [WIDTH:0]   w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_quo_next;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (r_rem),
    .quo_msb (r_quo[WIDTH-1]),
    .divisor (r_divisor),
    .rem_out (w_rem_next),
    .q_bit   (w_q_bit)
  );

  assign w_quo_next = {r_quo[WIDTH-2:0], w_q_bit};

  // FSM, iteration counter, operand capture and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              r_state     <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
            end else begin
              r_state   <= RUN;
              busy      <= 1'b1;
              r_count   <= '0;
              r_rem     <= '0;
              r_quo     <= dividend;
              r_divisor <= divisor;
            end
          end else if (r_state == DONE) begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= r_count + CNT_W'(1);
          if (r_count == CNT_W'(WIDTH - 1)) begin
            r_state   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= w_quo_next;
            remainder <= w_rem_next[WIDTH-1:0];
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : div_4bit_seq

// File: tb/tb_div_4bit_seq.sv
// Directed bench for div_4bit_seq: latency, divide-by-zero, start handling, reset abort, sweep.
module tb_div_4bit_seq;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_vec;
  int n_err;

  div_4bit_seq #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse, bounded wait for done, then compare results and latency.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] dv,
                        input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                        input logic exp_dbz, input int exp_lat);
    int cyc;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_q"}, 32'(quotient), 32'(exp_q));
    check({tag, "_r"}, 32'(remainder), 32'(exp_r));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    tick();
  endtask

  initial begin
    int dcount;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_r;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mr;

    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);

    // 13/3 with cycle-by-cycle latency checks.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    check("d13_busy0", 32'(busy), 32'd1);
    check("d13_done0", 32'(done), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("d13_busy", 32'(busy), 32'd1);
      check("d13_ndone", 32'(done), 32'd0);
    end
    tick();
    check("d13_done", 32'(done), 32'd1);
    check("d13_busyoff", 32'(busy), 32'd0);
    check("d13_q", 32'(quotient), 32'd4);
    check("d13_r", 32'(remainder), 32'd1);
    check("d13_dbz", 32'(div_by_zero), 32'd0);
    tick();
    check("d13_pulse", 32'(done), 32'd0);
    check("d13_hold_q", 32'(quotient), 32'd4);

    // 7/0 divide by zero.
    dividend = 4'd7;
    divisor  = 4'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("dbz_done", 32'(done), 32'd1);
    check("dbz_flag", 32'(div_by_zero), 32'd1);
    check("dbz_q", 32'(quotient), 32'hF);
    check("dbz_r", 32'(remainder), 32'd7);
    check("dbz_busy", 32'(busy), 32'd0);
    tick();
    check("dbz_pulse", 32'(done), 32'd0);
    check("dbz_hold", 32'(div_by_zero), 32'd1);
    check("dbz_busy2", 32'(busy), 32'd0);
    tick();

    run_op("d3_9", 4'd3, 4'd9, 4'd0, 4'd3, 1'b0, 5);
    run_op("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5);

    // start with 9/2 mid-RUN of 13/3 is ignored.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    tick();
    start  = 1'b0;
    dcount = 0;
    cap_q  = '0;
    cap_r  = '0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) begin
        dcount++;
        cap_q = quotient;
        cap_r = remainder;
      end
      tick();
    end
    check("ign_ndone", 32'(dcount), 32'd1);
    check("ign_q", 32'(cap_q), 32'd4);
    check("ign_r", 32'(cap_r), 32'd1);

    // Reset in the second RUN cycle aborts.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(quotient), 32'd0);
    check("abort_r", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    tick();
    check("abort_idle", 32'(busy), 32'd0);
    run_op("d10_3", 4'd10, 4'd3, 4'd3, 4'd1, 1'b0, 5);

    // start held across done: back-to-back 14/4.
    dividend = 4'd14;
    divisor  = 4'd4;
    start    = 1'b1;
    tick();
    tick();
    tick();
    tick();
    tick();
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_q1", 32'(quotient), 32'd3);
    check("b2b_r1", 32'(remainder), 32'd2);
    tick();
    start = 1'b0;
    check("b2b_drop", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    tick();
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_q2", 32'(quotient), 32'd3);
    check("b2b_r2", 32'(remainder), 32'd2);
    tick();
    check("b2b_end", 32'(done), 32'd0);
    check("b2b_idle", 32'(busy), 32'd0);

    // Exhaustive sweep against arithmetic reference.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          mq = 4'hF;
          mr = WIDTH'(a);
        end else begin
          mq = WIDTH'(a / b);
          mr = WIDTH'(a % b);
        end
        run_op($sformatf("sw_%0d_%0d", a, b), WIDTH'(a), WIDTH'(b), mq, mr,
               (b == 0), (b == 0) ? 1 : 5);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_div_4bit_seq
